// File: rtl/core_config_pkg.sv
// -----------------------------------------------------------------------------
// core_config_pkg
// Core-wide configuration shared by the ALU blocks: the datapath width and
// the RV32M multiply operation encoding used by the issue stage, the decoder
// and the multiply scheduler.
//   XLEN        : operand/result width
//   mul_op_t    : 2-bit multiply operation (MUL, MULH, MULHSU, MULHU)
//   mul_ctrl_t  : multiplier sign / high-low controls
//   decode_mul_op : mul_op_t -> mul_ctrl_t
// -----------------------------------------------------------------------------
package core_config_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        MUL_MUL    = 2'b00,
        MUL_MULH   = 2'b01,
        MUL_MULHSU = 2'b10,
        MUL_MULHU  = 2'b11
    } mul_op_t;

    typedef struct packed {
        logic signed_multiplicand;
        logic signed_multiplier;
        logic highlow;
    } mul_ctrl_t;

    // MULHSU treats rs1 (multiplicand) as signed and rs2 (multiplier) as
    // unsigned; only plain MUL returns the low half.
    function automatic mul_ctrl_t decode_mul_op(input mul_op_t op);
        mul_ctrl_t ctrl;
        ctrl = '0;
        case (op)
            MUL_MUL:    ctrl = '{signed_multiplicand: 1'b1, signed_multiplier: 1'b1, highlow: 1'b0};
            MUL_MULH:   ctrl = '{signed_multiplicand: 1'b1, signed_multiplier: 1'b1, highlow: 1'b1};
            MUL_MULHSU: ctrl = '{signed_multiplicand: 1'b1, signed_multiplier: 1'b0, highlow: 1'b1};
            MUL_MULHU:  ctrl = '{signed_multiplicand: 1'b0, signed_multiplier: 1'b0, highlow: 1'b1};
            default:    ctrl = '0;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/mul_scheduler_cache.sv
// -----------------------------------------------------------------------------
// mul_result_cache
// Single-entry memo of the last request that went through the multiplier.
// Written when the multiplier completes an un-flushed operation; the lookup
// is combinational so the scheduler can answer a repeat in the accept cycle.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset (clears valid)
//   wr_en             : store {wr_op, wr_rs1, wr_rs2, wr_res}
//   rd_op/rd_rs1/rd_rs2 : lookup key
//   hit, hit_data     : key matches a valid entry / stored result
// -----------------------------------------------------------------------------
module mul_result_cache
    import core_config_pkg::mul_op_t;
#(
    parameter int XLEN = core_config_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  mul_op_t         wr_op,
    input  logic [XLEN-1:0] wr_rs1,
    input  logic [XLEN-1:0] wr_rs2,
    input  logic [XLEN-1:0] wr_res,
    input  mul_op_t         rd_op,
    input  logic [XLEN-1:0] rd_rs1,
    input  logic [XLEN-1:0] rd_rs2,
    output logic            hit,
    output logic [XLEN-1:0] hit_data
);

    logic            valid_reg;
    mul_op_t         op_reg;
    logic [XLEN-1:0] rs1_reg;
    logic [XLEN-1:0] rs2_reg;
    logic [XLEN-1:0] res_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            op_reg    <= mul_op_t'(2'b00);
            rs1_reg   <= '0;
            rs2_reg   <= '0;
            res_reg   <= '0;
        end else if (wr_en) begin
            valid_reg <= 1'b1;
            op_reg    <= wr_op;
            rs1_reg   <= wr_rs1;
            rs2_reg   <= wr_rs2;
            res_reg   <= wr_res;
        end
    end

    assign hit      = valid_reg && (rd_op == op_reg) && (rd_rs1 == rs1_reg) && (rd_rs2 == rs2_reg);
    assign hit_data = res_reg;

endmodule

// File: rtl/mul_scheduler.sv
// -----------------------------------------------------------------------------
// mul_scheduler
// Sequences RV32M multiply requests into the radix-4 Booth multiplier.
// Requests with a zero operand, or identical to the last multiplier-computed
// request, are answered directly; everything else starts the multiplier and
// waits for its done pulse. A flush kills the in-flight operation; if the
// multiplier is already running its result is drained and discarded.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   req_valid/req_ready           : request handshake (ready only in IDLE)
//   req_op, req_rs1, req_rs2, req_tag : request payload
//   flush                         : discard the in-flight request
//   rsp_valid/rsp_ready           : response handshake
//   rsp_data, rsp_tag             : response payload
//   busy                          : not IDLE
//   mul_start, mul_multiplicand, mul_multiplier,
//   mul_signed_multiplicand, mul_signed_multiplier, mul_highlow : to multiplier
//   mul_res, mul_done             : from multiplier
// All outputs are registered.
// -----------------------------------------------------------------------------
module mul_scheduler
    import core_config_pkg::mul_op_t;
    import core_config_pkg::mul_ctrl_t;
    import core_config_pkg::decode_mul_op;
#(
    parameter int XLEN  = core_config_pkg::XLEN,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  mul_op_t          req_op,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic             mul_start,
    output logic [XLEN-1:0]  mul_multiplicand,
    output logic [XLEN-1:0]  mul_multiplier,
    output logic             mul_signed_multiplicand,
    output logic             mul_signed_multiplier,
    output logic             mul_highlow,
    input  logic [XLEN-1:0]  mul_res,
    input  logic             mul_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t           state_reg;
    logic             req_ready_reg;
    logic             rsp_valid_reg;
    logic             busy_reg;
    logic             mul_start_reg;
    logic [XLEN-1:0]  md_reg;
    logic [XLEN-1:0]  mr_reg;
    mul_ctrl_t        ctrl_reg;
    mul_op_t          op_reg;
    logic [TAG_W-1:0] tag_reg;
    logic [XLEN-1:0]  rsp_data_reg;
    logic [TAG_W-1:0] rsp_tag_reg;

    logic             accept;
    logic             zero_operand;
    logic             cache_hit;
    logic [XLEN-1:0]  cache_data;
    logic             cache_wr;

    // A flush in IDLE vetoes acceptance even though req_ready is high.
    assign accept       = req_valid && req_ready_reg && !flush;
    assign zero_operand = (req_rs1 == '0) || (req_rs2 == '0);
    // Only an un-flushed multiplier completion refreshes the cache.
    assign cache_wr     = (state_reg == S_WAIT) && mul_done && !flush;

    mul_result_cache #(
        .XLEN (XLEN)
    ) u_cache (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (cache_wr),
        .wr_op    (op_reg),
        .wr_rs1   (md_reg),
        .wr_rs2   (mr_reg),
        .wr_res   (mul_res),
        .rd_op    (req_op),
        .rd_rs1   (req_rs1),
        .rd_rs2   (req_rs2),
        .hit      (cache_hit),
        .hit_data (cache_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            mul_start_reg <= 1'b0;
            md_reg        <= '0;
            mr_reg        <= '0;
            ctrl_reg      <= '0;
            op_reg        <= mul_op_t'(2'b00);
            tag_reg       <= '0;
            rsp_data_reg  <= '0;
            rsp_tag_reg   <= '0;
        end else begin
            // Start is a single-cycle pulse, only raised on the IDLE->ISSUE step.
            mul_start_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    // Also brings req_ready up on the first edge after reset.
                    req_ready_reg <= 1'b1;
                    if (accept) begin
                        // Operands/controls are held from here until the next
                        // accept, which covers the whole multiplier run.
                        md_reg        <= req_rs1;
                        mr_reg        <= req_rs2;
                        ctrl_reg      <= decode_mul_op(req_op);
                        op_reg        <= req_op;
                        tag_reg       <= req_tag;
                        req_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        if (zero_operand) begin
                            rsp_data_reg  <= '0;
                            rsp_tag_reg   <= req_tag;
                            rsp_valid_reg <= 1'b1;
                            state_reg     <= S_RESP;
                        end else if (cache_hit) begin
                            rsp_data_reg  <= cache_data;
                            rsp_tag_reg   <= req_tag;
                            rsp_valid_reg <= 1'b1;
                            state_reg     <= S_RESP;
                        end else begin
                            mul_start_reg <= 1'b1;
                            state_reg     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    // The multiplier has been started, so a flush must drain it.
                    state_reg <= flush ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (flush) begin
                        if (mul_done) begin
                            state_reg     <= S_IDLE;
                            req_ready_reg <= 1'b1;
                            busy_reg      <= 1'b0;
                        end else begin
                            state_reg <= S_DRAIN;
                        end
                    end else if (mul_done) begin
                        rsp_data_reg  <= mul_res;
                        rsp_tag_reg   <= tag_reg;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= S_RESP;
                    end
                end
                S_RESP: begin
                    // Flush wins over a simultaneous rsp_ready: the result is dropped.
                    if (flush || rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (mul_done) begin
                        req_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end
                default: begin
                    state_reg     <= S_IDLE;
                    req_ready_reg <= 1'b1;
                    rsp_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready               = req_ready_reg;
    assign rsp_valid               = rsp_valid_reg;
    assign rsp_data                = rsp_data_reg;
    assign rsp_tag                 = rsp_tag_reg;
    assign busy                    = busy_reg;
    assign mul_start               = mul_start_reg;
    assign mul_multiplicand        = md_reg;
    assign mul_multiplier          = mr_reg;
    assign mul_signed_multiplicand = ctrl_reg.signed_multiplicand;
    assign mul_signed_multiplier   = ctrl_reg.signed_multiplier;
    assign mul_highlow             = ctrl_reg.highlow;

endmodule
